vga_capture: RTL and testbench



---
 rtl/vga_capture.sv | 168 ++++++++++++++++
 tb/tb_vga_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// Frame grabber: turns a VGA-timed RGB pixel stream into framebuffer writes
// (linear address y*H_ACTIVE+x, 3:3:3 colour) for one armed frame at a time.
module vga_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  vs,
    input  logic                  hs,
    input  logic                  active,
    input  logic [7:0]            r,
    input  logic [7:0]            g,
    input  logic [7:0]            b,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_SYNC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [10:0]           H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0]           V_LIM  = 11'(V_ACTIVE);
    localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_ACTIVE);

    function automatic logic [31:0] pack_rgb(input logic [7:0] rr, input logic [7:0] gg,
                                             input logic [7:0] bb);
        return {23'd0, rr[7:5], gg[7:5], bb[7:5]};
    endfunction

    state_t                  state_q, state_d;
    logic [10:0]             x_q, x_d, y_q, y_d;
    logic [ADDR_WIDTH-1:0]   line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [31:0]             data_q, data_d;
    logic                    write_q, write_d, busy_q, busy_d, done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic                    vs_prev_q, active_prev_q;
    logic                    vs_fall_s, vs_rise_s, act_fall_s;
    logic                    unused_s;

    // hs is monitored only and the low colour bits are truncated away
    assign unused_s   = ^{hs, r[4:0], g[4:0], b[4:0]};
    assign vs_fall_s  = vs_prev_q & ~vs;
    assign vs_rise_s  = ~vs_prev_q & vs;
    assign act_fall_s = active_prev_q & ~active;

    // Next-state, pixel position and write-port computation
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        line_base_d = line_base_q;
        write_d     = 1'b0;
        address_d   = address_q;
        data_d      = data_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_ARMED;
                    overflow_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARMED: begin
                if (!enable) state_d = S_IDLE;
                else if (vs_fall_s) state_d = S_SYNC;
                else state_d = S_ARMED;
            end
            S_SYNC: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (vs_rise_s) begin
                    state_d     = S_CAPTURE;
                    x_d         = 11'd0;
                    y_d         = 11'd0;
                    line_base_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_CAPTURE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (vs_fall_s) begin
                    // frame end wins over any pixel or line end in this cycle
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (active) begin
                    if ((x_q < H_LIM) && (y_q < V_LIM)) begin
                        write_d   = 1'b1;
                        address_d = line_base_q + ADDR_WIDTH'(x_q);
                        data_d    = pack_rgb(r, g, b);
                        x_d       = x_q + 11'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (act_fall_s) begin
                    x_d = 11'd0;
                    if (y_q < V_LIM) begin
                        y_d         = y_q + 11'd1;
                        line_base_d = line_base_q + H_STEP;
                    end else begin
                        y_d = y_q;
                    end
                end else begin
                    x_d = x_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ARMED) || (state_d == S_SYNC) || (state_d == S_CAPTURE);
    end

    // State, position counters, edge-detect history and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            x_q           <= 11'd0;
            y_q           <= 11'd0;
            line_base_q   <= {ADDR_WIDTH{1'b0}};
            address_q     <= {ADDR_WIDTH{1'b0}};
            data_q        <= 32'd0;
            write_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            vs_prev_q     <= 1'b0;
            active_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_base_q   <= line_base_d;
            address_q     <= address_d;
            data_q        <= data_d;
            write_q       <= write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
            vs_prev_q     <= vs;
            active_prev_q <= active;
        end
    end

    assign write    = write_q;
    assign address  = address_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed-sequence bench for vga_capture on a small 8x4 raster with random
// colours; expected writes come from the frame/line/pixel geometry.
module tb_vga_capture;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 19;

    logic          clock = 1'b0;
    logic          reset, enable, vs, hs, active;
    logic [7:0]    r, g, b;
    logic          write, busy, done, overflow;
    logic [AW-1:0] address;
    logic [31:0]   data;

    vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .vs(vs), .hs(hs),
        .active(active), .r(r), .g(g), .b(b), .write(write), .address(address),
        .data(data), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;
    logic          exp_write, exp_done;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    bit            cap_live, cap_open, ovf_exp;
    bit            fixed;
    logic [7:0]    fr, fg, fb;
    int            line_len [8];
    int            n_lines;

    function automatic logic [31:0] pack(input logic [7:0] rr, input logic [7:0] gg,
                                         input logic [7:0] bb);
        return {23'd0, rr[7:5], gg[7:5], bb[7:5]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        chk("write", 32'(write), 32'(exp_write));
        chk("address", 32'(address), 32'(exp_addr));
        chk("data", data, exp_data);
        chk("done", 32'(done), 32'(exp_done));
        exp_write = 1'b0;
        exp_done  = 1'b0;
    endtask

    task automatic blank(input int n);
        active = 1'b0;
        repeat (n) step();
    endtask

    task automatic pixel(input int l, input int p);
        if (fixed) begin
            r = fr; g = fg; b = fb;
        end else begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
        active = 1'b1;
        if (cap_live) begin
            if (l < V && p < H) begin
                exp_write = 1'b1;
                exp_addr  = AW'(l * H + p);
                exp_data  = pack(r, g, b);
            end else begin
                ovf_exp = 1'b1;
            end
        end
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        cap_live = 1'b0;
        cap_open = 1'b0;
        exp_addr = '0;
        exp_data = 32'd0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One frame: vs pulse (closing the previous frame), blanking, then lines.
    task automatic send_frame(input bit cap, input int en_line, input int drop_at,
                              input int rst_at);
        int pix = 0;
        vs = 1'b0; active = 1'b0;
        exp_done = cap_open;
        step();
        if (cap_open) chk("overflow_at_done", 32'(overflow), 32'(ovf_exp));
        cap_open = 1'b0;
        step();
        vs = 1'b1;
        step();
        if (cap) chk("busy_capture", 32'(busy), 32'd1);
        cap_live = cap;
        cap_open = cap;
        if (cap) ovf_exp = 1'b0;
        blank(2);
        for (int l = 0; l < n_lines; l++) begin
            if (l == en_line) enable = 1'b1;
            for (int p = 0; p < line_len[l]; p++) begin
                if (pix == rst_at) do_reset();
                if (pix == drop_at) begin
                    enable   = 1'b0;
                    cap_live = 1'b0;
                    cap_open = 1'b0;
                    pixel(l, p);
                    chk("busy_abort", 32'(busy), 32'd0);
                end else begin
                    pixel(l, p);
                end
                pix++;
            end
            blank(3);
        end
    endtask

    task automatic set_full();
        n_lines = V;
        for (int i = 0; i < V; i++) line_len[i] = H;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; vs = 1'b1; hs = 1'b1; active = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        exp_write = 1'b0; exp_done = 1'b0; exp_addr = '0; exp_data = 32'd0;
        cap_live = 1'b0; cap_open = 1'b0; ovf_exp = 1'b0; fixed = 1'b0;
        fr = 8'hE0; fg = 8'h20; fb = 8'h40;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_write", 32'(write), 32'd0);
        chk("reset_address", 32'(address), 32'd0);
        chk("reset_data", data, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        enable = 1'b1;
        blank(3);
        chk("busy_armed", 32'(busy), 32'd1);

        // A: full frame, constant colour, captured
        fixed = 1'b1; set_full();
        send_frame(1'b1, -1, -1, -1);
        fixed = 1'b0;

        // B: ragged frame during re-arm, not captured
        n_lines = 5;
        line_len[0] = 5; line_len[1] = 9; line_len[2] = 8; line_len[3] = 2; line_len[4] = 8;
        send_frame(1'b0, -1, -1, -1);

        // C: short line, overlong line, one line too many
        n_lines = 5;
        line_len[0] = 3; line_len[1] = 9; line_len[2] = 8; line_len[3] = 8; line_len[4] = 8;
        send_frame(1'b1, -1, -1, -1);

        // D: not captured; closes C with overflow
        set_full();
        send_frame(1'b0, -1, -1, -1);
        enable = 1'b0;
        blank(3);
        chk("busy_disabled", 32'(busy), 32'd0);

        // E: enable raised mid-frame, F is the first captured frame
        send_frame(1'b0, 2, -1, -1);
        chk("busy_mid_armed", 32'(busy), 32'd1);
        send_frame(1'b1, -1, -1, -1);
        send_frame(1'b0, -1, -1, -1);

        // H: enable dropped after 13 pixels
        send_frame(1'b1, -1, 13, -1);
        enable = 1'b1;
        blank(3);

        // I: reset mid-capture, J captured afterwards
        send_frame(1'b1, -1, -1, 10);
        send_frame(1'b1, -1, -1, -1);
        vs = 1'b0; active = 1'b0;
        exp_done = cap_open;
        step();
        chk("overflow_final", 32'(overflow), 32'(ovf_exp));
        vs = 1'b1;
        blank(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
